// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcode encodings,
// arbiter FSM state encoding and the undefined-opcode classifier.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_NOR   = 4'b0101;
    localparam logic [3:0] ALU_SLL   = 4'b0110;
    localparam logic [3:0] ALU_SRL   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;
    localparam logic [3:0] ALU_PASSA = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1011;
    localparam logic [3:0] ALU_BP8   = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

    // Opcodes 1101..1111 have no ALU function assigned.
    function automatic logic is_undef_op(input logic [3:0] op);
        return (op >= 4'b1101);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way grant logic with a round-robin pointer. The pointer only moves
// when the owner of the current grant completes its transaction.
module rr_arb2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_served,
    output logic       o_gnt_valid,
    output logic       o_gnt_id
);

    // 0 = port 0 favoured on a tie, 1 = port 1 favoured
    logic r_ptr;

    // Pointer favours the port that was not just served.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (i_update) begin
            r_ptr <= ~i_served;
        end
    end

    // Sole requester wins; ties go to the pointer (or port 0 when fixed).
    always_comb begin
        o_gnt_valid = |i_req;
        o_gnt_id    = 1'b0;
        case (i_req)
            2'b10:   o_gnt_id = 1'b1;
            2'b11:   o_gnt_id = (FIXED_PRIO != 0) ? 1'b0 : r_ptr;
            default: o_gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between the EX-stage port (0) and the branch/address port
// (1): accept one operation, drive the ALU for one cycle, capture the result
// and hold it on the winning port's response channel until it is taken.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int OPW        = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_out,
    output logic             rsp0_z,
    output logic             rsp0_n,
    output logic             rsp0_err,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_out,
    output logic             rsp1_z,
    output logic             rsp1_n,
    output logic             rsp1_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    input  logic             alu_n,
    output logic             busy
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [OPW-1:0]   r_op;
    logic             r_gid;

    logic [1:0]       w_req_valid;
    logic [1:0]       w_rsp_ready;
    logic [1:0]       w_req_ready;
    logic             w_gnt_valid;
    logic             w_gnt_id;
    logic             w_accept;
    logic             w_capture;
    logic             w_release;

    logic             r_rsp_valid [2];
    logic [WIDTH-1:0] r_rsp_out   [2];
    logic             r_rsp_z     [2];
    logic             r_rsp_n     [2];
    logic             r_rsp_err   [2];

    assign w_req_valid = {req1_valid, req0_valid};
    assign w_rsp_ready = {rsp1_ready, rsp0_ready};

    rr_arb2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr_arb2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_req       (w_req_valid),
        .i_update    (w_release),
        .i_served    (r_gid),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, handshake strobes and ALU drive; ALU inputs are idle-zero.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 2'b00;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_release    = 1'b0;
        alu_a        = '0;
        alu_b        = '0;
        alu_opcode   = '0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_req_ready[w_gnt_id] = 1'b1;
                    w_accept              = 1'b1;
                    w_state_next          = EXEC;
                end
            end
            EXEC: begin
                alu_a        = r_a;
                alu_b        = r_b;
                alu_opcode   = r_op;
                w_capture    = 1'b1;
                w_state_next = RESP;
            end
            RESP: begin
                if (w_rsp_ready[r_gid]) begin
                    w_release    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Latch the winning port's operands and identity on acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= '0;
            r_gid <= 1'b0;
        end else if (w_accept) begin
            r_a   <= w_gnt_id ? req1_a  : req0_a;
            r_b   <= w_gnt_id ? req1_b  : req0_b;
            r_op  <= w_gnt_id ? req1_op : req0_op;
            r_gid <= w_gnt_id;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rsp
            // Per-port response holding registers: load from the ALU at the
            // end of EXEC, drop valid/err when the consumer takes the result.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rsp_valid[gi] <= 1'b0;
                    r_rsp_out[gi]   <= '0;
                    r_rsp_z[gi]     <= 1'b0;
                    r_rsp_n[gi]     <= 1'b0;
                    r_rsp_err[gi]   <= 1'b0;
                end else if (w_capture && (r_gid == 1'(gi))) begin
                    r_rsp_valid[gi] <= 1'b1;
                    r_rsp_out[gi]   <= alu_out;
                    r_rsp_z[gi]     <= alu_z;
                    r_rsp_n[gi]     <= alu_n;
                    r_rsp_err[gi]   <= is_undef_op(r_op);
                end else if (w_release && (r_gid == 1'(gi))) begin
                    r_rsp_valid[gi] <= 1'b0;
                    r_rsp_err[gi]   <= 1'b0;
                end
            end
        end
    endgenerate

    assign req0_ready = w_req_ready[0];
    assign req1_ready = w_req_ready[1];
    assign rsp0_valid = r_rsp_valid[0];
    assign rsp0_out   = r_rsp_out[0];
    assign rsp0_z     = r_rsp_z[0];
    assign rsp0_n     = r_rsp_n[0];
    assign rsp0_err   = r_rsp_err[0];
    assign rsp1_valid = r_rsp_valid[1];
    assign rsp1_out   = r_rsp_out[1];
    assign rsp1_z     = r_rsp_z[1];
    assign rsp1_n     = r_rsp_n[1];
    assign rsp1_err   = r_rsp_err[1];
    assign busy       = (r_state != IDLE);

endmodule
